// File: rtl/mips_pkg.sv
// Shared MIPS definitions: exception vectors and the timer register map.
package mips_pkg;

    localparam logic [31:0] ILLOP = 32'h8000_0004;
    localparam logic [31:0] XADR  = 32'h8000_0008;

    // Byte offsets inside the timer window
    localparam logic [4:0] TMR_TH   = 5'h00;
    localparam logic [4:0] TMR_TL   = 5'h04;
    localparam logic [4:0] TMR_TCON = 5'h08;
    localparam logic [4:0] TMR_PSC  = 5'h0C;
    localparam logic [4:0] TMR_CNT  = 5'h10;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // Field order matches the TCON bit indices above
    typedef struct packed {
        logic st;
        logic ie;
        logic en;
    } tcon_t;

    function automatic logic [31:0] tcon_word(input tcon_t t);
        return {29'd0, t};
    endfunction

endpackage

// File: rtl/mips_timer_if.sv
// Data-memory bus slice seen by the timer: address, store/load strobes, read data, select.
interface mips_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] rdata;
    logic        sel;

    modport master (output addr, wdata, mem_wr, mem_rd, input rdata, sel);
    modport slave  (input addr, wdata, mem_wr, mem_rd, output rdata, sel);
endinterface

// File: rtl/timer_prescaler.sv
// Prescale counter for mips_timer: one tick every psc+1 enabled cycles.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] psc,
    input  logic        psc_wr,
    output logic        tick
);

    logic [15:0] count;

    assign tick = en && (count == psc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || psc_wr || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped 32-bit reload timer with level irq; optional prescaler under TIMER_PRESCALE_EN.
module mips_timer
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_timer_if.slave   bus,
    output logic          irq
);

    logic [31:0] th, tl, tl_n, cnt;
    tcon_t       tcon, tcon_n;
    logic [4:0]  off;
    logic        wr, tick, cnt_en, ovf;
    logic        unused_addr_lsb;

    assign bus.sel         = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off             = {bus.addr[4:2], 2'b00};
    assign unused_addr_lsb = ^bus.addr[1:0];
    assign wr              = bus.mem_wr & bus.sel;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc;
    logic        psc_wr;

    assign psc_wr = wr && (off == TMR_PSC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      psc <= '0;
        else if (psc_wr) psc <= bus.wdata[15:0];
    end

    timer_prescaler u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tcon.en),
        .psc    (psc),
        .psc_wr (psc_wr),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tl_n   = tl;
        tcon_n = tcon;
        ovf    = 1'b0;
        // A TCON write that clears EN freezes TL on its own edge
        cnt_en = tcon.en & ~(wr && (off == TMR_TCON) && !bus.wdata[TCON_EN]);
        if (tick && cnt_en) begin
            if (&tl) begin
                tl_n = th;
                ovf  = tcon.ie;
            end else begin
                tl_n = tl + 32'd1;
            end
        end
        if (wr && (off == TMR_TL)) tl_n = bus.wdata;
        if (wr && (off == TMR_TCON)) begin
            tcon_n.en = bus.wdata[TCON_EN];
            tcon_n.ie = bus.wdata[TCON_IE];
            tcon_n.st = tcon.st & bus.wdata[TCON_ST];
        end
        // Hardware set beats a software clear on the same edge
        if (ovf) tcon_n.st = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            cnt  <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr && (off == TMR_TH)) th <= bus.wdata;
            tl   <= tl_n;
            tcon <= tcon_n;
            cnt  <= cnt + 32'd1;
            irq  <= tcon_n.ie & tcon_n.st;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel && bus.mem_rd) begin
            case (off)
                TMR_TH:   bus.rdata = th;
                TMR_TL:   bus.rdata = tl;
                TMR_TCON: bus.rdata = tcon_word(tcon);
`ifdef TIMER_PRESCALE_EN
                TMR_PSC:  bus.rdata = {16'd0, psc};
`endif
                TMR_CNT:  bus.rdata = cnt;
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_timer.sv
// Directed self-checking bench for mips_timer; honours TIMER_PRESCALE_EN when defined.
module tb_mips_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE + 32'h00;
    localparam logic [31:0] A_TL = BASE + 32'h04;
    localparam logic [31:0] A_TC = BASE + 32'h08;
    localparam logic [31:0] A_PS = BASE + 32'h0C;
    localparam logic [31:0] A_CN = BASE + 32'h10;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] d;

    mips_timer_if bus ();

    mips_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus.addr   = a;
        bus.wdata  = v;
        bus.mem_wr = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr   = a;
        bus.mem_rd = 1'b1;
        #1;
        v          = bus.rdata;
        bus.mem_rd = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.mem_wr = 1'b0;
        bus.mem_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Reset state; CNT has seen one edge since release
        check("reset_irq", {31'd0, irq}, 32'd0);
        expect_reg("reset_th", A_TH, 32'd0);
        expect_reg("reset_tl", A_TL, 32'd0);
        expect_reg("reset_tcon", A_TC, 32'd0);
        expect_reg("reset_cnt", A_CN, 32'd1);

        // Decode and read gating
        bus.addr = BASE; #1;
        check("sel_in", {31'd0, bus.sel}, 32'd1);
        bus.addr = BASE + 32'h20; #1;
        check("sel_out", {31'd0, bus.sel}, 32'd0);
        bus.addr = A_CN; #1;
        check("rdata_no_rd", bus.rdata, 32'd0);

        // Ignored writes: CNT, hole, out-of-window alias, PSC
        wr(A_CN, 32'h1234);
        expect_reg("cnt_ro", A_CN, 32'd2);
        wr(BASE + 32'h14, 32'hDEAD_BEEF);
        expect_reg("hole_rd", BASE + 32'h14, 32'd0);
        wr(BASE + 32'h24, 32'h77);
        expect_reg("outside_wr", A_TL, 32'd0);
        wr(A_PS, 32'hABCD_0055);
`ifdef TIMER_PRESCALE_EN
        expect_reg("psc_rd", A_PS, 32'h0000_0055);
        wr(A_PS, 32'd0);
`else
        expect_reg("psc_absent", A_PS, 32'd0);
`endif

        // Reload from TH with interrupt
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFC);
        wr(A_TC, 32'd3);
        expect_reg("en_no_count", A_TL, 32'hFFFF_FFFC);
        step(3);
        expect_reg("tl_max", A_TL, 32'hFFFF_FFFF);
        check("irq_pre_ovf", {31'd0, irq}, 32'd0);
        step(1);
        expect_reg("tl_reload", A_TL, 32'hFFFF_FFFC);
        expect_reg("st_set", A_TC, 32'd7);
        check("irq_ovf", {31'd0, irq}, 32'd1);

        // Clear races the next overflow, then clears for real
        step(3);
        expect_reg("tl_max2", A_TL, 32'hFFFF_FFFF);
        wr(A_TC, 32'd3);
        expect_reg("race_st", A_TC, 32'd7);
        check("race_irq", {31'd0, irq}, 32'd1);
        wr(A_TC, 32'd3);
        expect_reg("clr_st", A_TC, 32'd3);
        check("clr_irq", {31'd0, irq}, 32'd0);

        // IE masking
        wr(A_TC, 32'd1);
        wr(A_TL, 32'hFFFF_FFFE);
        step(1);
        expect_reg("mask_max", A_TL, 32'hFFFF_FFFF);
        step(1);
        expect_reg("mask_reload", A_TL, 32'hFFFF_FFFC);
        expect_reg("mask_st", A_TC, 32'd1);
        check("mask_irq", {31'd0, irq}, 32'd0);

        // Software TL write on the overflow edge
        wr(A_TC, 32'd3);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TL, 32'd5);
        expect_reg("prio_tl", A_TL, 32'd5);
        expect_reg("prio_st", A_TC, 32'd7);
        check("prio_irq", {31'd0, irq}, 32'd1);

        // EN clear freezes on its edge; EN set counts from the next edge
        wr(A_TC, 32'd0);
        expect_reg("freeze_tl", A_TL, 32'd5);
        check("freeze_irq", {31'd0, irq}, 32'd0);
        step(2);
        expect_reg("frozen_tl", A_TL, 32'd5);
        wr(A_TC, 32'd1);
        expect_reg("start_tl", A_TL, 32'd5);
        step(1);
        expect_reg("run_tl", A_TL, 32'd6);

`ifdef TIMER_PRESCALE_EN
        wr(A_TC, 32'd0);
        wr(A_TL, 32'd0);
        wr(A_PS, 32'd3);
        wr(A_TC, 32'd1);
        step(3);
        expect_reg("psc_tl0", A_TL, 32'd0);
        step(1);
        expect_reg("psc_tl1", A_TL, 32'd1);
        step(4);
        expect_reg("psc_tl2", A_TL, 32'd2);
        wr(A_PS, 32'hABCD_0003);
        expect_reg("psc_width", A_PS, 32'h0000_0003);
        wr(A_PS, 32'd0);
`endif

        // Asynchronous reset while irq is high
        wr(A_TC, 32'd0);
        wr(A_TH, 32'd0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TC, 32'd3);
        step(1);
        check("async_pre_irq", {31'd0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_irq", {31'd0, irq}, 32'd0);
        expect_reg("async_th", A_TH, 32'd0);
        expect_reg("async_tl", A_TL, 32'd0);
        expect_reg("async_tcon", A_TC, 32'd0);
        expect_reg("async_cnt", A_CN, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        expect_reg("cnt_after1", A_CN, 32'd1);
        step(1);
        expect_reg("cnt_after2", A_CN, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
